// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative radix-2 restoring divider used by EX for RV64M DIV/REM.
// Define DIV_WORD_FAST_EN to run W ops in 32 iterations on left-aligned operands.
module div_seq_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            hold,
  input  logic [3:0]      div_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            stallreq,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] result
);

`ifdef DIV_WORD_FAST_EN
  localparam bit WFAST = 1'b1;
`else
  localparam bit WFAST = 1'b0;
`endif

  localparam int HALF = XLEN / 2;

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              word_q, word_d;
  logic              rem_op_q, rem_op_d;
  logic              unsgn_q, unsgn_d;
  logic [XLEN-1:0]   quo_q, quo_d;   // holds latched src1 in PREP, quotient shift reg in BUSY
  logic [XLEN-1:0]   dvs_q, dvs_d;   // holds latched src2 in PREP, divisor magnitude in BUSY
  logic [XLEN-1:0]   acc_q, acc_d;
  logic              qsign_q, qsign_d;
  logic              rsign_q, rsign_d;
  logic [XLEN-1:0]   result_q, result_d;

  function automatic logic [XLEN-1:0] wsext(input logic [XLEN-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic sgn);
    return {{HALF{sgn & v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  // Operand conditioning (PREP)
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, ovf_pat, spec_val;
  logic            s1, s2, div_zero, ovf;

  always_comb begin
    a_ext    = word_q ? wext(quo_q, ~unsgn_q) : quo_q;
    b_ext    = word_q ? wext(dvs_q, ~unsgn_q) : dvs_q;
    s1       = ~unsgn_q & a_ext[XLEN-1];
    s2       = ~unsgn_q & b_ext[XLEN-1];
    a_abs    = s1 ? -a_ext : a_ext;
    b_abs    = s2 ? -b_ext : b_ext;
    ovf_pat  = word_q ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = ~unsgn_q & (a_ext == ovf_pat) & (b_ext == '1);
    if (div_zero)
      spec_val = rem_op_q ? a_ext : '1;
    else
      spec_val = rem_op_q ? '0 : a_ext;
    if (word_q) spec_val = wsext(spec_val);
  end

  // One restoring step (BUSY); 65-bit compare covers divisors >= 2^63
  logic [XLEN:0]   acc_sh;
  logic            ge;
  logic [XLEN-1:0] acc_nx, quo_nx, q_fin, r_fin, fin_val;

  always_comb begin
    acc_sh  = {acc_q, quo_q[XLEN-1]};
    ge      = (acc_sh >= {1'b0, dvs_q});
    acc_nx  = ge ? (acc_sh[XLEN-1:0] - dvs_q) : acc_sh[XLEN-1:0];
    quo_nx  = {quo_q[XLEN-2:0], ge};
    q_fin   = qsign_q ? -quo_nx : quo_nx;
    r_fin   = rsign_q ? -acc_nx : acc_nx;
    fin_val = rem_op_q ? r_fin : q_fin;
    if (word_q) fin_val = wsext(fin_val);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    rem_op_d = rem_op_q;
    unsgn_d  = unsgn_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    qsign_d  = qsign_q;
    rsign_d  = rsign_q;
    result_d = result_q;
    stallreq = 1'b0;
    case (state_q)
      S_IDLE: begin
        stallreq = div_op[3];
        if (div_op[3]) begin
          quo_d    = src1;
          dvs_d    = src2;
          word_d   = div_op[2];
          rem_op_d = div_op[1];
          unsgn_d  = div_op[0];
          state_d  = S_PREP;
        end
      end
      S_PREP: begin
        stallreq = 1'b1;
        if (div_zero || ovf) begin
          result_d = spec_val;
          state_d  = S_DONE;
        end else begin
          if (WFAST && word_q) begin
            quo_d = {a_abs[HALF-1:0], {HALF{1'b0}}};
            cnt_d = CNT_W'(HALF - 1);
          end else begin
            quo_d = a_abs;
            cnt_d = CNT_W'(XLEN - 1);
          end
          dvs_d   = b_abs;
          acc_d   = '0;
          qsign_d = s1 ^ s2;
          rsign_d = s1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        stallreq = 1'b1;
        acc_d    = acc_nx;
        quo_d    = quo_nx;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = fin_val;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        // div_op deliberately ignored: the op still sitting in EX must not restart
        if (!hold) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      word_q   <= 1'b0;
      rem_op_q <= 1'b0;
      unsgn_q  <= 1'b0;
      quo_q    <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      word_q   <= word_d;
      rem_op_q <= rem_op_d;
      unsgn_q  <= unsgn_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      qsign_q  <= qsign_d;
      rsign_q  <= rsign_d;
      result_q <= result_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed ops push expected result/latency, a monitor checks each result pulse.
module tb_div_seq_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, hold = 1'b0;
  logic [3:0]  div_op = '0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        stallreq, busy, res_valid;
  logic [63:0] result;

  div_seq_ctrl #(.XLEN(64), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .hold(hold), .div_op(div_op),
    .src1(src1), .src2(src2), .stallreq(stallreq), .busy(busy),
    .res_valid(res_valid), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef DIV_WORD_FAST_EN
  localparam int LW = 34;
`else
  localparam int LW = 66;
`endif

  localparam logic [3:0] DIV = 4'b1000, DIVU = 4'b1001, REM = 4'b1010, REMU = 4'b1011;
  localparam logic [3:0] DIVW = 4'b1100, DIVUW = 4'b1101, REMW = 4'b1110;

  typedef struct {
    logic [63:0] res;
    int          issue;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop on the first cycle of each result pulse, check stability while it is held.
  logic        prev_rv = 1'b0;
  logic [63:0] last_res = '0;
  initial forever begin
    @(posedge clk);
    #1;
    if (res_valid === 1'b1) begin
      if (!prev_rv) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got result %h expected no pulse", result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_latency"}, 64'(cyc - e.issue), 64'(e.lat));
        end
        last_res = result;
      end else begin
        chk("held_result_stable", result, last_res);
      end
    end
    prev_rv = (res_valid === 1'b1);
  end

  task automatic run_op(input string nm, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int lat,
                        input int nhold);
    bit got;
    int n;
    sb.push_back('{exp, cyc, lat, nm});
    div_op = op; src1 = a; src2 = b;
    got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (res_valid) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no res_valid expected one within 200 cycles", nm);
      div_op = '0;
      return;
    end
    if (nhold > 0) begin
      hold = 1'b1;
      n = 1;
      repeat (nhold) begin
        @(negedge clk);
        if (res_valid) n++;
      end
      hold = 1'b0;
      chk({nm, "_hold_len"}, 64'(n), 64'(nhold + 1));
    end
    div_op = '0;
    @(negedge clk);
    chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    chk({nm, "_idle_rv"}, 64'(res_valid), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stallreq", 64'(stallreq), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("divu_100_7", DIVU, 64'd100, 64'd7, 64'd14, 66, 0);
    run_op("remu_100_7", REMU, 64'd100, 64'd7, 64'd2, 66, 0);
    run_op("div_m7_2",   DIV,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 0);
    run_op("rem_m7_2",   REM,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
    run_op("rem_7_m2",   REM,  64'd7, -64'sd2, 64'd1, 66, 0);
    run_op("div_5_0",    DIV,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
    run_op("remu_5_0",   REMU, 64'd5, 64'd0, 64'd5, 2, 0);
    run_op("div_ovf",    DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 2, 0);
    run_op("remw_ovf",   REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 2, 0);
    run_op("divw_neg",   DIVW, 64'hFFFF_FFFF_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, LW, 0);
    run_op("divuw_max",  DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, LW, 0);
    run_op("remw_m7_2",  REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LW, 0);
    run_op("remw_5_0",   REMW, 64'h1234_5678_0000_0005, 64'hABCD_0000_0000_0000, 64'd5, 2, 0);
    run_op("div_min_2",  DIV,  64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 66, 0);
    run_op("divu_big",   DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 0);
    run_op("remu_big",   REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 66, 0);
    run_op("divu_hold",  DIVU, 64'd1000, 64'd10, 64'd100, 66, 3);

    // Flush in the 10th BUSY cycle: no pulse, idle next cycle, new op accepted right after.
    div_op = DIVU; src1 = 64'd100; src2 = 64'd7;
    #1 chk("idle_stallreq_comb", 64'(stallreq), 64'd1);
    repeat (11) @(negedge clk);
    chk("busy_before_flush", 64'(busy), 64'd1);
    chk("stall_before_flush", 64'(stallreq), 64'd1);
    flush = 1'b1; div_op = '0;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_stallreq", 64'(stallreq), 64'd0);
    chk("flush_res_valid", 64'(res_valid), 64'd0);
    chk("flush_result", result, 64'd0);
    run_op("after_flush", DIV, -64'sd100, 64'd7, -64'sd14, 66, 0);

    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d pending results expected 0", sb.size());
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
